series_engine: RTL and testbench
================================

Name: series_engine

Overview:
- Parametrised iterative series-evaluation accelerator: controller FSM plus datapath in one block.
- Computes r = sum over k of (+/-) t_k, where t_0 = x and t_k = t_(k-1) * x^xpow * c_(k-1).
- Coefficients come from an external synchronous coefficient ROM.
- Successor to the fixed 4-state multiply/compare/add-sub controller. Adds configurable width, term count, x-power stride, sign mode, multiplier latency, saturation, abort and done handshake.

Parameters:
- W, 16, data width; signed fixed point with FRAC fractional bits.
- FRAC, 14, fractional bits (1.0 = 2^FRAC).
- NTERMS, 8, maximum number of series terms.
- AW, 3, coefficient address width; must be at least clog2(NTERMS).
- MUL_LAT, 2, wait cycles after each multiply issue (multiplier/ROM latency budget).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset; asserted when 0.
- start  in  1  request; accepted only while ready=1.
- abort  in  1  cancel current operation.
- x_in  in  W  signed operand, captured on accept.
- nterms_in  in  AW+1  number of terms, 1..NTERMS; captured on accept.
- xpow_in  in  2  x multiplications per term, 1..3; 0 is treated as 1; captured on accept.
- alt_in  in  1  1: alternate signs (+,-,+,...); 0: all terms added; captured on accept.
- coef_addr  out  AW  coefficient index k-1 while computing term k.
- coef_data  in  W  signed coefficient, valid MUL_LAT cycles after coef_addr changes.
- ready  out  1  idle, able to accept.
- done  out  1  one-cycle pulse; result valid.
- result  out  W  final sum; held until the next accept.
- ovf  out  1  sticky saturation flag for the current operation; cleared on accept.

Behaviour:
- Reset (rst=0, async):
  - State IDLE; ready=1; done=0; result=0; ovf=0; coef_addr=0.
  - Internal x, t, r, k, wait counter and sign all cleared.
- States: IDLE, MULX, WAITX, MULC, WAITC, ACC, DONE.
- IDLE:
  - ready=1.
  - On start=1 at a clock edge: capture operands; t=x_in, r=x_in, k=1, sign=- if alt_in else +; ovf=0.
  - Go to MULX if nterms>1, else DONE.
  - nterms_in=0 is treated as 1. nterms_in>NTERMS is clamped to NTERMS.
- MULX:
  - t <= sat(t*x). Then WAITX for MUL_LAT cycles.
  - Repeat MULX/WAITX xpow times, then go to MULC.
- MULC / WAITC:
  - coef_addr = k-1, stable from MULX of term k through ACC.
  - coef_data is sampled in the last WAITC cycle, or in the MULC cycle if MUL_LAT=0.
  - t <= sat(t*coef) at that point.
- ACC:
  - r <= sat(r +/- t).
  - If alt, toggle sign.
  - k <= k+1. If k+1 == nterms go to DONE, else MULX.
- DONE:
  - done=1 for one cycle; result <= r; ready=0.
  - Next state IDLE.
- Arithmetic:
  - Full 2W signed product, arithmetic shift right by FRAC (floor), saturate to [-2^(W-1), 2^(W-1)-1].
  - Sum uses W+1 bits, then saturates.
  - Any saturation sets ovf for the rest of the operation.
- Latency from accept edge to done:
  - (n-1)*((xpow+1)*(1+MUL_LAT)+1)+1 cycles, where n is the effective nterms.
- ready=0 in every state except IDLE. start while busy is ignored; no queueing.
- abort=1 in any non-IDLE state:
  - Next state IDLE; done not pulsed.
  - result and ovf keep their previous values.
  - abort in IDLE has no effect.
  - abort and start asserted together in IDLE: start wins.
- Reset mid-operation: immediate return to reset values; no done.
- Back-to-back operation: start held high across DONE is accepted in the IDLE cycle that follows.

Test Plan:
- W=16, FRAC=14, MUL_LAT=2; x=8192 (0.5), nterms=3, xpow=2, alt=1, coef[0]=2731, coef[1]=819 -> done at accept+21 cycles, result=7855 (sin 0.5), ovf=0.
- nterms=1, x=-5000 -> done at accept+1, result=-5000, coef_addr stays 0; repeat with nterms=0 -> same result.
- x=24576 (1.5), nterms=2, xpow=1, alt=0, coef[0]=16384 -> t saturates at 32767, result=32767, ovf=1; the next accept clears ovf.
- Abort asserted 5 cycles after accept -> ready=1 the next cycle, no done pulse, result keeps its previous value; a new start then runs to completion normally.
- start pulsed in the middle of the first test's operation -> ignored; exactly one done at accept+21.
- rst=0 asynchronously mid-operation -> ready=1, result=0, ovf=0 immediately, without waiting for a clock edge; no done.

Source files
------------

// File: rtl/series_engine.sv
// Iterative series evaluator: r = sum of (+/-) t_k, t_k = t_(k-1) * x^xpow * c_(k-1).
// One FSM sequences a shared saturating fixed-point multiplier and adder.
module series_engine #(
    parameter int W       = 16,
    parameter int FRAC    = 14,
    parameter int NTERMS  = 8,
    parameter int AW      = 3,
    parameter int MUL_LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [W-1:0]  x_in,
    input  logic [AW:0]   nterms_in,
    input  logic [1:0]    xpow_in,
    input  logic          alt_in,
    output logic [AW-1:0] coef_addr,
    input  logic [W-1:0]  coef_data,
    output logic          ready,
    output logic          done,
    output logic [W-1:0]  result,
    output logic          ovf
);
    typedef enum logic [2:0] {IDLE, MULX, WAITX, MULC, WAITC, ACC, DONE} state_t;

    localparam int WCW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [WCW-1:0] WLAST = (MUL_LAT > 0) ? WCW'(MUL_LAT - 1) : '0;
    localparam logic [AW:0] NMAX  = (AW+1)'(NTERMS);
    localparam logic [AW:0] ONE_N = (AW+1)'(1);
    localparam logic signed [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

    state_t                state_q;
    logic signed [W-1:0]   x_q, t_q, r_q;
    logic [AW:0]           k_q, n_q;
    logic [1:0]            xpow_q, xcnt_q;
    logic [WCW-1:0]        wcnt_q;
    logic                  alt_q, sign_q;
    logic                  ready_q, done_q, ovf_q;
    logic [W-1:0]          result_q;
    logic [AW-1:0]         coef_addr_q;

    assign ready     = ready_q;
    assign done      = done_q;
    assign result    = result_q;
    assign ovf       = ovf_q;
    assign coef_addr = coef_addr_q;

    // Operand normalisation: 0 terms behaves as 1, oversize counts clamp to NTERMS.
    logic [AW:0] n_eff;
    logic [1:0]  xpow_eff;

    // NOTE: the default assignment first keeps this block purely combinational (no latch).
    always_comb begin
        n_eff = nterms_in;
        if (nterms_in == '0) begin
            n_eff = ONE_N;
        end else if (nterms_in > NMAX) begin
            n_eff = NMAX;
        end
    end

    assign xpow_eff = (xpow_in == 2'd0) ? 2'd1 : xpow_in;

    // Shared multiplier: full 2W product, floor shift by FRAC, saturate to W bits.
    logic signed [W-1:0]   mul_b, mul_res;
    logic signed [2*W-1:0] prod, prod_sh;
    logic                  mul_ovf;

    assign mul_b   = (state_q == MULX) ? x_q : $signed(coef_data);
    assign prod    = t_q * mul_b;
    assign prod_sh = prod >>> FRAC;
    assign mul_ovf = !((&prod_sh[2*W-1:W-1]) || !(|prod_sh[2*W-1:W-1]));
    assign mul_res = mul_ovf ? (prod_sh[2*W-1] ? SMIN : SMAX) : prod_sh[W-1:0];

    // Accumulator adder in W+1 bits so the overflow is visible before saturation.
    logic signed [W:0]   r_ext, t_ext, sum_w;
    logic                add_ovf;
    logic signed [W-1:0] add_res;

    assign r_ext   = {r_q[W-1], r_q};
    assign t_ext   = {t_q[W-1], t_q};
    assign sum_w   = sign_q ? (r_ext - t_ext) : (r_ext + t_ext);
    assign add_ovf = sum_w[W] != sum_w[W-1];
    assign add_res = add_ovf ? (sum_w[W] ? SMIN : SMAX) : sum_w[W-1:0];

    logic [AW:0] k_next;
    logic        last_term, wait_last;

    assign k_next    = k_q + ONE_N;
    assign last_term = (k_next == n_q);
    assign wait_last = (wcnt_q == WLAST);

    // NOTE: every register, datapath included, is cleared by the async reset so an
    // interrupted operation can never leak stale operands into the next one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            x_q         <= '0;
            t_q         <= '0;
            r_q         <= '0;
            k_q         <= '0;
            n_q         <= '0;
            xpow_q      <= '0;
            xcnt_q      <= '0;
            wcnt_q      <= '0;
            alt_q       <= 1'b0;
            sign_q      <= 1'b0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
            result_q    <= '0;
            coef_addr_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (abort && state_q != IDLE) begin
                state_q <= IDLE;
                ready_q <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            x_q         <= x_in;
                            t_q         <= x_in;
                            r_q         <= x_in;
                            k_q         <= ONE_N;
                            n_q         <= n_eff;
                            xpow_q      <= xpow_eff;
                            xcnt_q      <= '0;
                            wcnt_q      <= '0;
                            alt_q       <= alt_in;
                            sign_q      <= alt_in;
                            ovf_q       <= 1'b0;
                            coef_addr_q <= '0;
                            ready_q     <= 1'b0;
                            if (n_eff > ONE_N) begin
                                state_q <= MULX;
                            end else begin
                                state_q  <= DONE;
                                done_q   <= 1'b1;
                                result_q <= x_in;
                            end
                        end
                    end
                    MULX: begin
                        t_q    <= mul_res;
                        xcnt_q <= xcnt_q + 2'd1;
                        wcnt_q <= '0;
                        if (mul_ovf) ovf_q <= 1'b1;
                        if (MUL_LAT > 0) begin
                            state_q <= WAITX;
                        end else if (xcnt_q + 2'd1 == xpow_q) begin
                            state_q <= MULC;
                        end
                    end
                    WAITX: begin
                        if (wait_last) begin
                            state_q <= (xcnt_q == xpow_q) ? MULC : MULX;
                        end else begin
                            wcnt_q <= wcnt_q + 1'b1;
                        end
                    end
                    MULC: begin
                        // With no latency budget the coefficient is already valid here.
                        if (MUL_LAT == 0) begin
                            t_q     <= mul_res;
                            state_q <= ACC;
                            if (mul_ovf) ovf_q <= 1'b1;
                        end else begin
                            wcnt_q  <= '0;
                            state_q <= WAITC;
                        end
                    end
                    WAITC: begin
                        if (wait_last) begin
                            t_q     <= mul_res;
                            state_q <= ACC;
                            if (mul_ovf) ovf_q <= 1'b1;
                        end else begin
                            wcnt_q <= wcnt_q + 1'b1;
                        end
                    end
                    ACC: begin
                        r_q    <= add_res;
                        k_q    <= k_next;
                        xcnt_q <= '0;
                        if (add_ovf) ovf_q <= 1'b1;
                        if (alt_q) sign_q <= ~sign_q;
                        if (last_term) begin
                            state_q  <= DONE;
                            done_q   <= 1'b1;
                            result_q <= add_res;
                        end else begin
                            coef_addr_q <= k_q[AW-1:0];
                            state_q     <= MULX;
                        end
                    end
                    DONE: begin
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                    default: begin
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_series_engine.sv
// Directed bench for series_engine: a driver pushes expected results into a scoreboard
// queue, and a negedge monitor pops and compares whenever done is presented.
module tb_series_engine;
    localparam int W       = 16;
    localparam int FRAC    = 14;
    localparam int NTERMS  = 8;
    localparam int AW      = 3;
    localparam int MUL_LAT = 2;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          start     = 1'b0;
    logic          abort     = 1'b0;
    logic [W-1:0]  x_in      = '0;
    logic [AW:0]   nterms_in = '0;
    logic [1:0]    xpow_in   = '0;
    logic          alt_in    = 1'b0;
    logic [AW-1:0] coef_addr;
    logic [W-1:0]  coef_data = '0;
    logic          ready, done, ovf;
    logic [W-1:0]  result;

    logic [W-1:0]  coef_mem [NTERMS];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        string name;
        int    res;
        bit    ovf;
        int    lat;
        int    acc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    series_engine #(
        .W(W), .FRAC(FRAC), .NTERMS(NTERMS), .AW(AW), .MUL_LAT(MUL_LAT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .x_in(x_in),
        .nterms_in(nterms_in), .xpow_in(xpow_in), .alt_in(alt_in),
        .coef_addr(coef_addr), .coef_data(coef_data), .ready(ready), .done(done),
        .result(result), .ovf(ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Synchronous coefficient ROM model.
    always @(posedge clk) coef_data <= coef_mem[coef_addr];

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.name, "_result"}, $signed(result), mon_e.res);
                check({mon_e.name, "_ovf"}, ovf, mon_e.ovf);
                check({mon_e.name, "_latency"}, cyc - mon_e.acc, mon_e.lat);
                check({mon_e.name, "_ready_low"}, ready, 0);
            end
        end
    end

    task automatic set_coefs(input int c0, input int c1, input int crest);
        for (int i = 0; i < NTERMS; i++) begin
            coef_mem[i] = (i == 0) ? c0[W-1:0] : (i == 1) ? c1[W-1:0] : crest[W-1:0];
        end
    endtask

    task automatic issue(input string name, input int x, input int n, input int xp,
                         input bit alt, input bit push, input int res, input bit eovf,
                         input int lat, input bit keep, input bit with_abort,
                         output int acc);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!ready && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 1000) check({name, "_ready_timeout"}, 0, 1);
        x_in      = x[W-1:0];
        nterms_in = n[AW:0];
        xpow_in   = xp[1:0];
        alt_in    = alt;
        abort     = with_abort;
        start     = 1'b1;
        acc       = cyc;
        if (push) sb.push_back('{name, res, eovf, lat, cyc});
        @(negedge clk);
        if (!keep) start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int guard;
        guard = 0;
        @(negedge clk);
        while ((sb.size() != 0 || !ready) && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 1000) begin
            check({name, "_idle_timeout"}, 0, 1);
            sb.delete();
        end
    endtask

    initial begin
        int acc;
        set_coefs(2731, 819, 0);

        #1 rst = 1'b0;
        #2;
        check("reset_ready", ready, 1);
        check("reset_done", done, 0);
        check("reset_result", $signed(result), 0);
        check("reset_ovf", ovf, 0);
        check("reset_coef_addr", coef_addr, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // sin(0.5) with three alternating terms.
        issue("sin", 8192, 3, 2, 1'b1, 1'b1, 7855, 1'b0, 21, 1'b0, 1'b0, acc);
        wait_idle("sin");

        issue("n1", -5000, 1, 1, 1'b0, 1'b1, -5000, 1'b0, 1, 1'b0, 1'b0, acc);
        check("n1_coef_addr", coef_addr, 0);
        wait_idle("n1");

        // nterms=0 behaves as 1; abort together with start in IDLE must lose to start.
        issue("n0", -5000, 0, 1, 1'b0, 1'b1, -5000, 1'b0, 1, 1'b0, 1'b1, acc);
        wait_idle("n0");

        set_coefs(16384, 16384, 16384);
        issue("sat", 24576, 2, 1, 1'b0, 1'b1, 32767, 1'b1, 8, 1'b0, 1'b0, acc);
        wait_idle("sat");

        // Floor rounding of a negative product: -16386 >>> 14 = -2, not -1.
        set_coefs(-1, 0, 0);
        issue("floor", 16385, 2, 1, 1'b0, 1'b1, 16383, 1'b0, 8, 1'b0, 1'b0, acc);
        check("ovf_cleared_on_accept", ovf, 0);
        wait_idle("floor");

        set_coefs(2731, 819, 0);
        issue("abort_op", 8192, 3, 2, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, acc);
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_ready", ready, 1);
        check("abort_no_done", done, 0);
        check("abort_result_kept", $signed(result), 16383);
        check("abort_ovf_kept", ovf, 0);

        set_coefs(16384, 16384, 16384);
        issue("xpow0", 8192, 2, 0, 1'b0, 1'b1, 12288, 1'b0, 8, 1'b0, 1'b0, acc);
        wait_idle("xpow0");

        issue("negsat", -24576, 2, 2, 1'b0, 1'b1, -32768, 1'b1, 11, 1'b0, 1'b0, acc);
        wait_idle("negsat");

        // nterms above NTERMS clamps to NTERMS: 7 terms of 7 cycles plus DONE.
        issue("clamp", 0, 15, 1, 1'b1, 1'b1, 0, 1'b0, 50, 1'b0, 1'b0, acc);
        wait_idle("clamp");

        set_coefs(2731, 819, 0);
        issue("midstart", 8192, 3, 2, 1'b1, 1'b1, 7855, 1'b0, 21, 1'b0, 1'b0, acc);
        repeat (6) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("midstart");

        // start held through DONE is accepted in the following IDLE cycle.
        issue("b2b_a", 8192, 3, 2, 1'b1, 1'b1, 7855, 1'b0, 21, 1'b1, 1'b0, acc);
        issue("b2b_b", 8192, 3, 2, 1'b1, 1'b1, 7855, 1'b0, 21, 1'b0, 1'b0, acc);
        check("b2b_second_accept", acc, 0 + acc);
        wait_idle("b2b");

        set_coefs(16384, 16384, 16384);
        issue("rst_op", 24576, 2, 1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, acc);
        repeat (2) @(negedge clk);
        check("rst_op_ovf_set", ovf, 1);
        #2 rst = 1'b0;
        #1;
        check("async_rst_ready", ready, 1);
        check("async_rst_done", done, 0);
        check("async_rst_result", $signed(result), 0);
        check("async_rst_ovf", ovf, 0);
        check("async_rst_coef_addr", coef_addr, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (25) @(negedge clk);

        set_coefs(2731, 819, 0);
        issue("after_rst", 8192, 3, 2, 1'b1, 1'b1, 7855, 1'b0, 21, 1'b0, 1'b0, acc);
        wait_idle("after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
